fp_adder_pipe: RTL and testbench

Parametrised, pipelined floating-point adder/subtractor for the Maxnet datapath. It takes two IEEE-754-style operands, aligns them, adds or subtracts them, and normalises the result. Rounding is round-to-nearest-even using guard/round/sticky bits. The block has a valid/ready handshake on both sides, so it can sit between the weight/activation buffers and the Maxnet inhibition accumulator, and it accepts one operation per cycle.

---
 rtl/fp_pkg.sv | 51 +++++
 rtl/fp_lzc_norm.sv | 21 ++
 rtl/fp_adder_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_fp_adder_pipe.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point helpers: format defaults, bias, field extract/pack and
// special-value builders. Helpers work on a 64-bit container; callers size-cast.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_MAX_W = 64;

  typedef logic [FP_MAX_W-1:0] fp_word_t;

  localparam fp_word_t FP_POS_ZERO = '0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic fp_word_t fp_exp_mask(input int exp_w);
    return (fp_word_t'(1) << exp_w) - fp_word_t'(1);
  endfunction

  function automatic fp_word_t fp_man_mask(input int man_w);
    return (fp_word_t'(1) << man_w) - fp_word_t'(1);
  endfunction

  function automatic logic fp_sign(input fp_word_t x, input int exp_w, input int man_w);
    return x[exp_w + man_w];
  endfunction

  function automatic fp_word_t fp_exp(input fp_word_t x, input int exp_w, input int man_w);
    return (x >> man_w) & fp_exp_mask(exp_w);
  endfunction

  function automatic fp_word_t fp_man(input fp_word_t x, input int man_w);
    return x & fp_man_mask(man_w);
  endfunction

  function automatic fp_word_t fp_pack(input logic s, input fp_word_t e, input fp_word_t m,
                                       input int exp_w, input int man_w);
    return (fp_word_t'(s) << (exp_w + man_w)) | ((e & fp_exp_mask(exp_w)) << man_w) |
           (m & fp_man_mask(man_w));
  endfunction

  function automatic fp_word_t fp_inf(input logic s, input int exp_w, input int man_w);
    return fp_pack(s, fp_exp_mask(exp_w), FP_POS_ZERO, exp_w, man_w);
  endfunction

  function automatic fp_word_t fp_nan(input int exp_w, input int man_w);
    return fp_pack(1'b0, fp_exp_mask(exp_w), fp_word_t'(1) << (man_w - 1), exp_w, man_w);
  endfunction

endpackage

// File: rtl/fp_lzc_norm.sv
// Combinational leading-zero count and left shift that brings the first set bit
// of the value to the MSB. An all-zero value reports a count of WIDTH.
module fp_lzc_norm #(
  parameter  int WIDTH = 28,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] norm,
  output logic [CNT_W-1:0] count
);

  // Scanning upward leaves the count of the highest set bit as the final value.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
    norm = value << count;
  end

endmodule

// File: rtl/fp_adder_pipe.sv
// Pipelined floating-point adder/subtractor: align, add, normalise, then round
// into the output register, with one global advance for valid/ready flow.
module fp_adder_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = FP_EXP_W,
  parameter  int MAN_W = FP_MAN_W,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         ovf
);

  localparam int F   = MAN_W + 5;
  localparam int SHW = $clog2(F) + 1;
  localparam int EXW = ((EXP_W > SHW) ? EXP_W : SHW) + 2;
  localparam logic [EXP_W-1:0]      EXP_ONES = '1;
  localparam logic signed [EXW-1:0] EXP_MAX  = EXW'((1 << EXP_W) - 1);
  localparam logic signed [EXW-1:0] EXP_ZERO = '0;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_big;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  assign sa     = fp_sign(fp_word_t'(a), EXP_W, MAN_W);
  assign sb     = fp_sign(fp_word_t'(b), EXP_W, MAN_W) ^ sub;
  assign ea     = EXP_W'(fp_exp(fp_word_t'(a), EXP_W, MAN_W));
  assign eb     = EXP_W'(fp_exp(fp_word_t'(b), EXP_W, MAN_W));
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES);
  assign b_inf  = (eb == EXP_ONES);
  assign ma     = a_zero ? '0 : MAN_W'(fp_man(fp_word_t'(a), MAN_W));
  assign mb     = b_zero ? '0 : MAN_W'(fp_man(fp_word_t'(b), MAN_W));
  assign a_big  = ({ea, ma} >= {eb, mb});

  logic                 big_sign, small_sign, small_zero;
  logic [EXP_W-1:0]     big_exp, small_exp, exp_diff;
  logic [MAN_W:0]       big_hid, small_hid;
  logic [2*MAN_W+3:0]   small_ext;
  logic [MAN_W+3:0]     small_al;
  logic                 nan_c, inf_c, inf_sign_c;

  // Swap so the larger magnitude is on the big side, then align the small one
  // keeping guard, round and a sticky OR of everything shifted past them.
  always_comb begin
    if (a_big) begin
      big_sign   = sa;
      big_exp    = ea;
      big_hid    = a_zero ? '0 : {1'b1, ma};
      small_sign = sb;
      small_exp  = eb;
      small_hid  = b_zero ? '0 : {1'b1, mb};
      small_zero = b_zero;
    end else begin
      big_sign   = sb;
      big_exp    = eb;
      big_hid    = b_zero ? '0 : {1'b1, mb};
      small_sign = sa;
      small_exp  = ea;
      small_hid  = a_zero ? '0 : {1'b1, ma};
      small_zero = a_zero;
    end
    exp_diff  = big_exp - small_exp;
    small_ext = {small_hid, {(MAN_W+3){1'b0}}} >> exp_diff;
    if (small_zero)
      small_al = '0;
    else if (32'(exp_diff) >= MAN_W + 3)
      small_al = {{(MAN_W+3){1'b0}}, 1'b1};
    else
      small_al = {small_ext[2*MAN_W+3:MAN_W+1], |small_ext[MAN_W:0]};
    nan_c      = a_inf && b_inf && (sa != sb);
    inf_c      = a_inf || b_inf;
    inf_sign_c = a_inf ? sa : sb;
  end

  logic             s1_valid, s2_valid, s3_valid;
  logic             s1_sign, s1_sub, s1_nan, s1_inf, s1_inf_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W+3:0] s1_big, s1_small;

  logic             s2_sign, s2_nan, s2_inf, s2_inf_sign;
  logic [EXP_W-1:0] s2_exp;
  logic [F-1:0]     s2_sum, sum_c;

  assign sum_c = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                        : ({1'b0, s1_big} + {1'b0, s1_small});

  logic [F-1:0]   norm;
  logic [SHW-1:0] lz;

  fp_lzc_norm #(.WIDTH(F)) u_lzc (
    .value (s2_sum),
    .norm  (norm),
    .count (lz)
  );

  logic                  s3_sign, s3_nan, s3_inf, s3_inf_sign, s3_zero;
  logic signed [EXW-1:0] s3_exp, n_exp;
  logic [F-2:0]          s3_field, n_field;

  // The carry bit sits above the hidden bit, so a normalised sum needs one
  // less left shift than its raw leading-zero count.
  always_comb begin
    if (s2_sum[F-1]) begin
      n_field = {s2_sum[F-1:2], s2_sum[1] | s2_sum[0]};
      n_exp   = EXW'(s2_exp) + EXW'(1);
    end else begin
      n_field = {norm[F-1:2], norm[1] | norm[0]};
      n_exp   = EXW'(s2_exp) - EXW'(lz) + EXW'(1);
    end
  end

  logic                  inc;
  logic [MAN_W+1:0]      rnd;
  logic [MAN_W-1:0]      r_man;
  logic signed [EXW-1:0] r_exp;
  logic [W-1:0]          y_c;
  logic                  ovf_c;

  always_comb begin
    inc   = s3_field[2] & (s3_field[1] | s3_field[0] | s3_field[3]);
    rnd   = {1'b0, s3_field[F-2:3]} + (MAN_W+2)'(inc);
    r_man = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    r_exp = s3_exp + EXW'(rnd[MAN_W+1]);
    ovf_c = 1'b0;
    y_c   = W'(FP_POS_ZERO);
    if (s3_nan) begin
      y_c = W'(fp_nan(EXP_W, MAN_W));
    end else if (s3_inf) begin
      y_c = W'(fp_inf(s3_inf_sign, EXP_W, MAN_W));
    end else if (s3_zero) begin
      y_c = W'(FP_POS_ZERO);
    end else if (r_exp <= EXP_ZERO) begin
      y_c = W'(fp_pack(s3_sign, FP_POS_ZERO, FP_POS_ZERO, EXP_W, MAN_W));
    end else if (r_exp >= EXP_MAX) begin
      y_c   = W'(fp_inf(s3_sign, EXP_W, MAN_W));
      ovf_c = 1'b1;
    end else begin
      y_c = W'(fp_pack(s3_sign, fp_word_t'(r_exp[EXP_W-1:0]), fp_word_t'(r_man),
                       EXP_W, MAN_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      y         <= y_c;
      ovf       <= ovf_c;
    end
  end

  // Datapath stages carry no reset; bubbles are tracked by the valid bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign     <= big_sign;
      s1_sub      <= big_sign ^ small_sign;
      s1_exp      <= big_exp;
      s1_big      <= {big_hid, 3'b000};
      s1_small    <= small_al;
      s1_nan      <= nan_c;
      s1_inf      <= inf_c;
      s1_inf_sign <= inf_sign_c;

      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum_c;
      s2_nan      <= s1_nan;
      s2_inf      <= s1_inf;
      s2_inf_sign <= s1_inf_sign;

      s3_sign     <= s2_sign;
      s3_exp      <= n_exp;
      s3_field    <= n_field;
      s3_zero     <= (s2_sum == '0);
      s3_nan      <= s2_nan;
      s3_inf      <= s2_inf;
      s3_inf_sign <= s2_inf_sign;
    end
  end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed-vector bench for fp_adder_pipe in single precision: latency, rounding,
// specials, backpressure ordering/stability and mid-stream reset.
module tb_fp_adder_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;

  int assertCount = 0;
  int failCount   = 0;

  fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] va;
    logic [31:0] vb;
    logic        vsub;
    logic [31:0] ey;
    logic        eovf;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] bpA[8];
  logic [31:0] bpY[8];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called just after a rising edge with an empty pipeline and out_ready=1.
  task automatic applyStimulus(input string tag, input logic [31:0] va, input logic [31:0] vb,
                               input logic vsub, input logic [31:0] ey, input logic eovf);
    a = va;
    b = vb;
    sub = vsub;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_early"}, 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'(1));
    checkOutput({tag, "_y"}, 64'(y), 64'(ey));
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(eovf));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          nIn;
    int          nOut;
    logic        holding;
    logic        accepted;
    logic [31:0] held;

    vecs[0]  = '{"add_1_1",      32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0};
    vecs[1]  = '{"sub_1_1",      32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0};
    vecs[2]  = '{"sub_3_1",      32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0};
    vecs[3]  = '{"rne_tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0};
    vecs[4]  = '{"rne_tie_up",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0};
    vecs[5]  = '{"sticky_only",  32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0};
    vecs[6]  = '{"overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1};
    vecs[7]  = '{"inf_m_inf",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0};
    vecs[8]  = '{"ninf_p_1",     32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0};
    vecs[9]  = '{"sub_1_ulp",    32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 1'b0};
    vecs[10] = '{"underflow",    32'h80800001, 32'h80800000, 1'b1, 32'h80000000, 1'b0};
    vecs[11] = '{"denorm_flush", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0};
    vecs[12] = '{"neg_sum",      32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 1'b0};
    vecs[13] = '{"sticky_sub",   32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 1'b0};

    bpA = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    bpY = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_y", 64'(y), 64'(0));
    checkOutput("reset_ovf", 64'(ovf), 64'(0));
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      applyStimulus(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].ey, vecs[i].eovf);

    @(posedge clk); #1;
    $display("[TB] backpressure stream");
    nIn = 0;
    nOut = 0;
    holding = 1'b0;
    held = '0;
    for (int k = 0; k < 200 && nOut < 8; k++) begin
      out_ready = (k % 3 == 0);
      in_valid = (nIn < 8);
      if (nIn < 8) begin
        a = bpA[nIn];
        b = 32'h3F800000;
        sub = 1'b0;
      end
      @(negedge clk);
      checkOutput("bp_in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (holding) checkOutput("bp_hold", 64'(y), 64'(held));
      if (out_valid && out_ready) begin
        checkOutput("bp_y", 64'(y), 64'(bpY[nOut]));
        nOut++;
        holding = 1'b0;
      end else if (out_valid) begin
        holding = 1'b1;
        held = y;
      end else begin
        holding = 1'b0;
      end
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) nIn++;
    end
    checkOutput("bp_count", 64'(nOut), 64'(8));
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("bp_no_dup", 64'(out_valid), 64'(0));
    end

    $display("[TB] reset with three operations in flight");
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      a = bpA[i];
      b = 32'h3F800000;
      sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_mid_y", 64'(y), 64'(0));
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("rst_stale", 64'(out_valid), 64'(0));
    end
    applyStimulus("post_rst", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
